// File: rtl/led_seq_pkg.sv
// Shared state and mode encodings for the LED chase sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FIRE      = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_PING = 2'b10
  } mode_e;

  // The unused encoding 2'b11 runs as forward.
  function automatic mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_REV;
      2'b10:   return MODE_PING;
      default: return MODE_FWD;
    endcase
  endfunction

endpackage

// File: rtl/led_chase_sequencer_gap_timer.sv
// Loadable down-counter with a zero flag; times the inter-channel gap and,
// when enabled, the per-channel done watchdog.
module led_seq_gap_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         cnt_en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_chase_sequencer.sv
// Chase sequencer: fires one breathing-LED channel at a time in forward,
// reverse or ping-pong order. Optional done watchdog: LED_SEQ_TIMEOUT_EN.
module led_chase_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LED   = 8,
  parameter int unsigned GAP     = 10,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned IDX_W   = $clog2(N_LED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [N_LED-1:0] done_i,
  output logic [N_LED-1:0] start_o,
  output logic [IDX_W-1:0] active_idx,
  output logic             busy,
  output logic             cycle_done,
  output logic             err
);

  localparam int unsigned      GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(N_LED - 1);
  localparam logic [N_LED-1:0] ONE      = N_LED'(1);

  if ((N_LED < 2) || (N_LED > 32) || (TIMEOUT < 1)) begin : g_bad_params
    $error("led_chase_sequencer: N_LED must be 2..32 and TIMEOUT >= 1");
  end

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, mode_in;
  logic [IDX_W-1:0] idx_q, idx_d, idx_nxt;
  logic             dir_q, dir_d, dir_nxt;
  logic             cdone_q, cdone_d;
  logic             gap_load, gap_zero, done_sel, advance;

  function automatic logic [IDX_W-1:0] start_of(input mode_e m);
    return (m == MODE_REV) ? LAST : '0;
  endfunction

  assign mode_in  = norm_mode(mode);
  assign done_sel = done_i[idx_q];

  led_seq_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .cnt_en_i   (state_q == S_GAP),
    .zero_o     (gap_zero)
  );

`ifdef LED_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic wd_zero, timeout;

  // Loaded while FIRE so it reads zero exactly TIMEOUT clocks after the start.
  led_seq_gap_timer #(.W(WD_W)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_FIRE),
    .load_val_i (WD_W'(TIMEOUT - 1)),
    .cnt_en_i   (state_q == S_WAIT_DONE),
    .zero_o     (wd_zero)
  );

  assign timeout = (state_q == S_WAIT_DONE) && wd_zero;
  assign advance = done_sel || timeout;
  assign err     = timeout && !done_sel;
`else
  assign advance = done_sel;
  assign err     = 1'b0;
`endif

  always_comb begin
    idx_nxt = idx_q;
    dir_nxt = 1'b1;
    case (mode_q)
      MODE_REV: idx_nxt = (idx_q == '0) ? LAST : idx_q - IDX_W'(1);
      MODE_PING: begin
        idx_nxt = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
        if (idx_nxt == LAST)     dir_nxt = 1'b0;
        else if (idx_nxt == '0)  dir_nxt = 1'b1;
        else                     dir_nxt = dir_q;
      end
      default:  idx_nxt = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    cdone_d  = 1'b0;
    gap_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          mode_d  = mode_in;
          idx_d   = start_of(mode_in);
          dir_d   = 1'b1;
          state_d = S_FIRE;
        end
      end
      S_FIRE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (advance) begin
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            // Pass boundary: mode is re-sampled and the new pass start loaded.
            if (idx_nxt == start_of(mode_q)) begin
              cdone_d = 1'b1;
              mode_d  = mode_in;
              idx_d   = start_of(mode_in);
              dir_d   = 1'b1;
            end else begin
              idx_d = idx_nxt;
              dir_d = dir_nxt;
            end
            if (GAP == 0) begin
              state_d = S_FIRE;
            end else begin
              state_d  = S_GAP;
              gap_load = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (!enable)       state_d = S_IDLE;
        else if (gap_zero) state_d = S_FIRE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_FWD;
      idx_q   <= '0;
      dir_q   <= 1'b1;
      cdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      cdone_q <= cdone_d;
    end
  end

  assign start_o    = (state_q == S_FIRE) ? (ONE << idx_q) : '0;
  assign active_idx = idx_q;
  assign busy       = (state_q != S_IDLE);
  assign cycle_done = cdone_q;

endmodule

// File: doc/led_chase_sequencer.md
Name: led_chase_sequencer

Overview:
- Upstream orchestrator for a bank of breathing-LED PWM controllers.
- Fires a one-cycle start pulse to one controller channel at a time, then waits for that channel's end-of-breath overflow pulse.
- Inserts a programmable gap, then advances to the next channel in forward, reverse or ping-pong order.
- Produces the chase / knight-rider animation across the LED strip.

Parameters:
- N_LED, 8, number of controller channels (2..32)
- GAP, 10, idle clocks between a channel's done pulse and the next start pulse (0 = no gap)
- TIMEOUT, 1023, watchdog limit in clocks for one channel's done (used only with the optional feature)
- IDX_W, $clog2(N_LED), derived width of the channel index

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  run request, level-sensitive
- mode  in  2  00 forward, 01 reverse, 10 ping-pong, 11 treated as forward
- done_i  in  N_LED  per-channel end-of-breath pulse (controller overflow)
- start_o  out  N_LED  one-hot, one-cycle start pulse to the selected channel
- active_idx  out  IDX_W  channel currently being driven
- busy  out  1  high in any state except IDLE
- cycle_done  out  1  one-cycle pulse when a full pattern pass completes
- err  out  1  one-cycle watchdog pulse (held 0 without the optional feature)

Behaviour:
- Reset values: start_o=0, active_idx=0, busy=0, cycle_done=0, err=0, state=IDLE, direction=up.
- IDLE:
  - If enable=1, latch mode and load the start index: forward/ping-pong 0, reverse N_LED-1.
  - Go to FIRE next clock.
- FIRE:
  - start_o[active_idx]=1 for exactly this cycle.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Only done_i[active_idx] is observed; all other done_i bits are ignored.
  - A done pulse on the same edge FIRE exits is not possible (controller latency ≥1), so it is not handled specially.
  - On done_i[active_idx]=1, compute the next index and go to GAP, or to FIRE directly if GAP=0.
- GAP:
  - Down-counter loaded with GAP-1; on reaching 0, go to FIRE.
- Index update:
  - Forward: wraps N_LED-1 -> 0.
  - Reverse: wraps 0 -> N_LED-1.
  - Ping-pong: sequence 0,1..N_LED-1,N_LED-2..1,0,1... with endpoints not repeated. The direction flag flips when the new index reaches 0 or N_LED-1.
- cycle_done:
  - Pulses on the clock the index is updated back to the pass start index.
  - The pass start index is 0 for forward/ping-pong and N_LED-1 for reverse.
  - Ping-pong pass length is 2*(N_LED-1) channels.
- mode:
  - Re-sampled only at cycle boundaries (with cycle_done) and in IDLE.
  - Mid-pass changes are deferred.
- enable deassert mid-operation:
  - The current channel completes through done_i.
  - Then, instead of GAP/FIRE, go to IDLE with active_idx held; busy drops on entry to IDLE.
  - Re-enable restarts from the pass start index.
- enable deasserted in GAP: go to IDLE immediately, with no further start pulse.
- Async rst at any point: immediate return to reset values. No pending start pulse survives.
- Arithmetic: index math is modulo N_LED in IDX_W bits and must be correct for non-power-of-2 N_LED. The gap counter is $clog2(GAP+1) bits wide.

Optional Feature:
- Macro: LED_SEQ_TIMEOUT_EN
- When defined:
  - A watchdog counter clears on entry to WAIT_DONE.
  - If TIMEOUT clocks elapse without done_i[active_idx], err pulses for 1 cycle.
  - The sequencer then advances exactly as if done had arrived (GAP, next index).
  - A done arriving on the same cycle as the timeout counts as done, so err=0.
- When undefined: no counter is built, err is tied 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package led_seq_pkg holds:
  - the state encoding (IDLE, FIRE, WAIT_DONE, GAP)
  - the mode constants MODE_FWD, MODE_REV, MODE_PING
- Sub-module led_seq_gap_timer (load, count-down, zero flag), reused by the watchdog when LED_SEQ_TIMEOUT_EN is set.

Test Plan:
- Forward: N_LED=4, GAP=3, enable held, done_i[idx] returned 20 clocks after each start. Expect:
  - start_o sequence 0001,0010,0100,1000,0001
  - each start exactly 4 clocks after the prior done
  - cycle_done once per 4 channels
- Ping-pong: N_LED=4, mode=10. Expect index order 0,1,2,3,2,1,0,1 and cycle_done on each return to 0 (every 6 channels).
- Reverse: GAP=0, mode=01. Expect start order 3,2,1,0,3, with each start on the clock after done.
- Stray done: pulse done_i[2] while idx=1. Expect no advance; the sequencer still waits for done_i[1].
- Stop mid-run:
  - Drop enable during WAIT_DONE on idx 2, then send done. Expect busy=0 next clock and no further start_o.
  - Assert rst mid-GAP. Expect all outputs 0 in the same cycle.
- With LED_SEQ_TIMEOUT_EN and TIMEOUT=50: withhold done. Expect err pulse at clock 50 after FIRE, then the next channel starts after GAP. Done and timeout on the same cycle -> err=0.
